// File: rtl/ahb_master_req_ctrl_pkg.sv
// Shared AHB types and helpers for the master request controller and its arbiters.
package ahb_master_req_ctrl_pkg;

    // AHB burst encoding (HBURST[2:0])
    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_type;

    // HTRANS encodings used by this master (BUSY is never issued)
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Request controller states
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StXfer = 2'b10
    } req_state_e;

    // Index of the last beat of a burst; the arbiter's beat monitor uses the same table.
    // Undefined-length INCR is treated as a single beat.
    function automatic logic [3:0] burst_limit(input hburst_type burst);
        logic [3:0] limit;
        case (burst)
            WRAP4, INCR4:   limit = 4'd3;
            WRAP8, INCR8:   limit = 4'd7;
            WRAP16, INCR16: limit = 4'd15;
            default:        limit = 4'd0;
        endcase
        return limit;
    endfunction

endpackage

// File: rtl/ahb_master_req_ctrl_burst_addr_gen.sv
// Combinational next-beat address for AHB bursts (word transfers, +4 byte step).
module ahb_master_req_ctrl_burst_addr_gen
    import ahb_master_req_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  hburst_type        i_burst,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] w_mask;
    logic [ADDR_W-1:0] w_incr;

    // Wrap window mask: only the bits inside the window advance, upper bits are frozen.
    // An all-ones mask degenerates to a plain incrementing add.
    always_comb begin
        w_mask = '1;
        case (i_burst)
            WRAP4:   w_mask = ADDR_W'(32'h0000_000F);
            WRAP8:   w_mask = ADDR_W'(32'h0000_001F);
            WRAP16:  w_mask = ADDR_W'(32'h0000_003F);
            default: w_mask = '1;
        endcase
    end

    // Merge the frozen upper bits with the incremented in-window bits
    always_comb begin
        w_incr = i_addr + ADDR_W'(4);
        o_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
    end

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// Master-side request controller: decodes the target slave for one command, requests
// that slave's arbiter, and issues the burst's address-phase beats once granted.
module ahb_master_req_ctrl
    import ahb_master_req_ctrl_pkg::*;
#(
    parameter int unsigned SLAVE_NUM = 2,
    parameter int unsigned PRIOR_BIT = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned SEL_LSB   = 28,
    parameter int unsigned SEL_W     = 1
) (
    input  logic                 i_hclk,
    input  logic                 i_hreset,
    // Command interface from the master core
    input  logic                 i_m_valid,
    output logic                 o_m_ready,
    input  logic [ADDR_W-1:0]    i_m_addr,
    input  logic                 i_m_write,
    input  hburst_type           i_m_burst,
    input  logic [PRIOR_BIT-1:0] i_m_prior,
    output logic                 o_m_err,
    output logic                 o_m_done,
    // Arbiter request / grant
    output logic [SLAVE_NUM-1:0] o_hreq,
    output logic [PRIOR_BIT-1:0] o_hprior,
    input  logic [SLAVE_NUM-1:0] i_hgrant,
    // Address phase
    output logic [ADDR_W-1:0]    o_haddr,
    output logic                 o_hwrite,
    output logic [1:0]           o_htrans,
    output hburst_type           o_hburst
);

    req_state_e           r_state;
    req_state_e           w_state_nxt;
    logic [SLAVE_NUM-1:0] r_hreq;
    logic [SLAVE_NUM-1:0] w_hreq_nxt;
    logic [PRIOR_BIT-1:0] r_hprior;
    logic [PRIOR_BIT-1:0] w_hprior_nxt;
    logic [ADDR_W-1:0]    r_haddr;
    logic [ADDR_W-1:0]    w_haddr_nxt;
    logic                 r_hwrite;
    logic                 w_hwrite_nxt;
    hburst_type           r_hburst;
    hburst_type           w_hburst_nxt;
    logic [3:0]           r_count;
    logic [3:0]           w_count_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_err;
    logic                 w_err_nxt;

    logic [SEL_W-1:0]     w_idx;
    logic                 w_idx_ok;
    logic [SLAVE_NUM-1:0] w_sel_onehot;
    logic                 w_grant;
    logic [3:0]           w_limit;
    logic [ADDR_W-1:0]    w_addr_next;

    // Slave decode of the incoming command address
    always_comb begin
        w_idx        = i_m_addr[SEL_LSB +: SEL_W];
        w_idx_ok     = (32'(w_idx) < SLAVE_NUM);
        w_sel_onehot = SLAVE_NUM'(1) << w_idx;
    end

    // r_hreq is one-hot on the target, so masking the grants drops non-target bits
    // and any grant seen while idle (r_hreq is zero there).
    always_comb begin
        w_grant = |(i_hgrant & r_hreq);
        w_limit = burst_limit(r_hburst);
    end

    ahb_master_req_ctrl_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_addr  (r_haddr),
        .i_burst (r_hburst),
        .o_addr  (w_addr_next)
    );

    // Next-state and datapath update; hreq/hprior only move on entry to REQ and on completion
    always_comb begin
        w_state_nxt  = r_state;
        w_hreq_nxt   = r_hreq;
        w_hprior_nxt = r_hprior;
        w_haddr_nxt  = r_haddr;
        w_hwrite_nxt = r_hwrite;
        w_hburst_nxt = r_hburst;
        w_count_nxt  = r_count;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_m_valid) begin
                    if (w_idx_ok) begin
                        w_state_nxt  = StReq;
                        w_hreq_nxt   = w_sel_onehot;
                        w_hprior_nxt = i_m_prior;
                        w_haddr_nxt  = i_m_addr;
                        w_hwrite_nxt = i_m_write;
                        w_hburst_nxt = i_m_burst;
                        w_count_nxt  = 4'd0;
                    end else begin
                        // Decode miss: command is consumed and dropped
                        w_err_nxt = 1'b1;
                    end
                end
            end

            StReq: begin
                // Beat 0 (NONSEQ) is accepted on the first target grant
                if (w_grant) begin
                    if (w_limit == 4'd0) begin
                        w_state_nxt  = StIdle;
                        w_hreq_nxt   = '0;
                        w_hprior_nxt = '0;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = StXfer;
                        w_count_nxt = 4'd1;
                        w_haddr_nxt = w_addr_next;
                    end
                end
            end

            StXfer: begin
                // Without a grant the current beat is simply held
                if (w_grant) begin
                    if (r_count == w_limit) begin
                        w_state_nxt  = StIdle;
                        w_hreq_nxt   = '0;
                        w_hprior_nxt = '0;
                        w_count_nxt  = 4'd0;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_count_nxt = r_count + 4'd1;
                        w_haddr_nxt = w_addr_next;
                    end
                end
            end

            default: begin
                w_state_nxt  = StIdle;
                w_hreq_nxt   = '0;
                w_hprior_nxt = '0;
                w_count_nxt  = 4'd0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously at any point of a burst
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_state  <= StIdle;
            r_hreq   <= '0;
            r_hprior <= '0;
            r_haddr  <= '0;
            r_hwrite <= 1'b0;
            r_hburst <= SINGLE;
            r_count  <= 4'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hreq   <= w_hreq_nxt;
            r_hprior <= w_hprior_nxt;
            r_haddr  <= w_haddr_nxt;
            r_hwrite <= w_hwrite_nxt;
            r_hburst <= w_hburst_nxt;
            r_count  <= w_count_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Output decode: transfer type follows the state directly
    always_comb begin
        o_m_ready = (r_state == StIdle);
        unique case (r_state)
            StReq:   o_htrans = HTRANS_NONSEQ;
            StXfer:  o_htrans = HTRANS_SEQ;
            default: o_htrans = HTRANS_IDLE;
        endcase
        o_hreq   = r_hreq;
        o_hprior = r_hprior;
        o_haddr  = r_haddr;
        o_hwrite = r_hwrite;
        o_hburst = r_hburst;
        o_m_done = r_done;
        o_m_err  = r_err;
    end

endmodule

// File: doc/ahb_master_req_ctrl.md
Name: ahb_master_req_ctrl

Overview:
Master-side request controller that sits directly upstream of the per-slave arbiters. It accepts one command (address, burst, priority) from a master core and decodes the target slave. It drives that slave's arbiter request and priority lines, waits for grant, then issues the burst's address-phase beats. It drops the request on the last accepted beat, consistent with the arbiter's own beat monitor.

Parameters:
SLAVE_NUM, 2, number of slaves (arbiters) this master can reach
PRIOR_BIT, 2, width of the priority value presented to each arbiter
ADDR_W, 32, address width
SEL_LSB, 28, lowest address bit of the slave-select field
SEL_W, 1, width of the slave-select field; decoded index must be < SLAVE_NUM

Ports:
hclk  in  1  clock, rising edge
hreset  in  1  asynchronous, active-high reset
m_valid  in  1  command valid from master core
m_ready  out  1  command accepted when m_valid & m_ready
m_addr  in  ADDR_W  start address, word aligned
m_write  in  1  write command
m_burst  in  hburst_type  burst type of command
m_prior  in  PRIOR_BIT  requested priority
m_err  out  1  one-cycle pulse: decode miss, command dropped
m_done  out  1  one-cycle pulse: last beat accepted
hreq  out  SLAVE_NUM  one-hot request to target slave's arbiter
hprior  out  PRIOR_BIT  priority to arbiters (held while hreq≠0)
hgrant  in  SLAVE_NUM  this master's grant bit from each arbiter (already qualified by ~hwait)
haddr  out  ADDR_W  address-phase address
hwrite  out  1  address-phase direction
htrans  out  2  IDLE=00, NONSEQ=10, SEQ=11
hburst  out  hburst_type  burst type, held for whole transaction

Behaviour:
- Reset (any time, including mid-burst): state IDLE; hreq=0, hprior=0, haddr=0, hwrite=0, htrans=IDLE, hburst=SINGLE, m_ready=1, m_err=0, m_done=0, beat count=0.
- States: IDLE, REQ, XFER.
- IDLE: m_ready=1. On m_valid, register addr/write/burst/prior; idx=m_addr[SEL_LSB+:SEL_W].
  - If idx<SLAVE_NUM: go to REQ. hreq[idx]=1 from the next cycle.
  - Otherwise: pulse m_err next cycle and stay in IDLE.
- REQ: m_ready=0; hreq held; htrans=NONSEQ, haddr=start address. Once hgrant[idx]=1, beat 0 is accepted.
  - If limit=0: go to IDLE and pulse m_done.
  - Otherwise: go to XFER with count=1.
- XFER: htrans=SEQ. Each cycle hgrant[idx]=1 accepts a beat, advances the address, and increments count.
  - When count==limit is accepted: drop hreq the following cycle, pulse m_done, return to IDLE.
  - hgrant low (slave wait or grant lost): hold haddr/htrans/count unchanged.
- Beat limit (count_limit): SINGLE/INCR→0; WRAP4/INCR4→3; WRAP8/INCR8→7; WRAP16/INCR16→15. Count is 4 bits.
- Address step is +4 bytes.
  - INCR*: plain add.
  - WRAP*: only bits [log2(4*beats)-1:2] increment, modulo. Example: WRAP4 from 0x38 gives 0x38,0x3C,0x30,0x34.
  - Upper bits never change during a wrap.
- hgrant on a non-target index is ignored. hgrant in IDLE is ignored.
- hreq/hprior change only in IDLE→REQ and at completion; never mid-burst.
- m_done and m_err are never asserted together.

Decomposition:
- AHB_package: hburst_type (already present), htrans constants (HTRANS_IDLE/NONSEQ/SEQ), and a function burst_limit(hburst_type) returning the 4-bit count_limit. The arbiter's monitor uses the same function.
- Sub-module ahb_burst_addr_gen: combinational next-address from (haddr, hburst). Holds the INCR/WRAP mask logic and is unit-tested standalone.

Test Plan:
1. SINGLE write to 0x0000_0010, hgrant[0] high one cycle after hreq → hreq=01 for exactly 1 grant cycle; htrans=NONSEQ; m_done pulses; back to IDLE, m_ready=1.
2. INCR4 read at 0x1000_0000 (slave 1), hgrant[1] continuous → haddr 0x1000_0000/04/08/0C; htrans NONSEQ,SEQ,SEQ,SEQ; hreq=10 dropped after 4th beat.
3. WRAP4 at 0x0000_0038 with hgrant deasserted for 2 cycles after beat 1 → addresses 0x38,0x3C(held 2 cycles),0x30,0x34; count unchanged while stalled.
4. INCR8 with hgrant[1] pulsed (bit not targeted) during REQ on slave-0 command → no beat advances, haddr stays start address.
5. SEL_W=2, SLAVE_NUM=2, address with idx=3 → m_err pulse 1 cycle, hreq stays 0, m_ready returns 1.
6. hreset asserted at beat 5 of INCR16 → same edge: hreq=0, htrans=IDLE, state IDLE. After release, a new SINGLE command completes normally.
